// File: rtl/mac_vector_adder_tree.sv
// mac_vector_adder_tree
//
// Pipelined signed dot-product engine. Multiplies two N-element signed
// vectors element-wise and reduces the products through a binary adder
// tree, producing one signed 2*WIDTH sum per clock.
//
// Optional feature macro: MAC_TREE_PIPE_EN
//   defined   : register after every adder level except the last,
//               latency = 1 + ceil(log2(N)) edges
//   undefined : purely combinational tree between the product registers
//               and the result register, latency = 2 edges
//
// Flow control: there is no valid/ready handshake. A vector pair is
// sampled on every rising edge and its sum appears on `result` exactly
// L edges later; consecutive pairs give consecutive results, in order.
//
// Arithmetic: products are full 2*WIDTH signed values. Each tree level
// widens by one bit, so the tree itself never overflows. The final sum
// is truncated to its low 2*WIDTH bits (two's-complement wrap).
// Non-power-of-two N is zero-padded to the next power of two.

module mac_vector_adder_tree #(
  parameter int N     = 8,
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [WIDTH-1:0]   vector_A [0:N-1],
  input  logic signed [WIDTH-1:0]   vector_B [0:N-1],
  output logic signed [2*WIDTH-1:0] result
);

  localparam int LEVELS = $clog2(N);
  localparam int NP     = 1 << LEVELS;
  localparam int PW     = 2 * WIDTH;

  genvar gi;
  genvar gk;
  genvar gj;

  // Combinational products; padding lanes are constant zero.
  logic signed [PW-1:0] prod_c [0:NP-1];

  for (gi = 0; gi < NP; gi++) begin : g_prod
    if (gi < N) begin : g_live
      logic signed [PW-1:0] a_ext;
      logic signed [PW-1:0] b_ext;
      assign a_ext      = {{WIDTH{vector_A[gi][WIDTH-1]}}, vector_A[gi]};
      assign b_ext      = {{WIDTH{vector_B[gi][WIDTH-1]}}, vector_B[gi]};
      assign prod_c[gi] = a_ext * b_ext;
    end else begin : g_pad
      assign prod_c[gi] = '0;
    end
  end

  // Level 0 holds the registered products; level k holds NP>>k nodes,
  // each PW+k bits wide, formed by adding adjacent pairs of level k-1.
  for (gk = 0; gk <= LEVELS; gk++) begin : lvl
    localparam int NW = PW + gk;
    localparam int NC = NP >> gk;

    logic signed [NW-1:0] node [0:NC-1];

    if (gk == 0) begin : g_stage0
      // Product register: first pipeline stage, cleared asynchronously.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < NC; i++) node[i] <= '0;
        end else begin
          for (int i = 0; i < NC; i++) node[i] <= prod_c[i];
        end
      end
    end else begin : g_add
      logic signed [NW-1:0] sum_c [0:NC-1];

      for (gj = 0; gj < NC; gj++) begin : g_pair
        logic signed [NW-2:0] lhs;
        logic signed [NW-2:0] rhs;
        assign lhs        = lvl[gk-1].node[2*gj];
        assign rhs        = lvl[gk-1].node[2*gj+1];
        // Sign-extend by one bit so the pair sum cannot overflow.
        assign sum_c[gj]  = {lhs[NW-2], lhs} + {rhs[NW-2], rhs};
      end

`ifdef MAC_TREE_PIPE_EN
      if (gk < LEVELS) begin : g_reg
        // Inter-level pipeline register, cleared asynchronously.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int i = 0; i < NC; i++) node[i] <= '0;
          end else begin
            for (int i = 0; i < NC; i++) node[i] <= sum_c[i];
          end
        end
      end else begin : g_last
        // The last level feeds the result register directly.
        assign node = sum_c;
      end
`else
      assign node = sum_c;
`endif
    end
  end

  // Output register: wrap the full-width tree sum to 2*WIDTH bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else begin
      result <= lvl[LEVELS].node[0][PW-1:0];
    end
  end

endmodule

// File: tb/tb_mac_vector_adder_tree.sv
// tb_mac_vector_adder_tree
//
// Directed bench for mac_vector_adder_tree with N=8, WIDTH=16.
// Expected sums are hand-computed constants. Build with or without
// MAC_TREE_PIPE_EN; the expected latency follows the same macro.

module tb_mac_vector_adder_tree;

  localparam int N     = 8;
  localparam int WIDTH = 16;
`ifdef MAC_TREE_PIPE_EN
  localparam int L = 4;
`else
  localparam int L = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic signed [WIDTH-1:0]   vec_a [0:N-1];
  logic signed [WIDTH-1:0]   vec_b [0:N-1];
  logic signed [2*WIDTH-1:0] result;

  mac_vector_adder_tree #(.N(N), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .vector_A (vec_a),
    .vector_B (vec_b),
    .result   (result)
  );

  // ---------------- stimulus tables ----------------
  logic signed [WIDTH-1:0] basic_a [0:N-1] = '{16'sd5, 16'sd7, 16'sd4, 16'sd1, 16'sd9, 16'sd2, 16'sd3, 16'sd6};
  logic signed [WIDTH-1:0] basic_b [0:N-1] = '{16'sd3, 16'sd2, 16'sd6, 16'sd8, 16'sd0, 16'sd5, 16'sd7, 16'sd4};
  logic signed [WIDTH-1:0] neg_a   [0:N-1] = '{-16'sd5, 16'sd7, -16'sd4, 16'sd1, 16'sd9, -16'sd2, 16'sd3, 16'sd6};
  logic signed [WIDTH-1:0] neg_b   [0:N-1] = '{16'sd3, -16'sd2, 16'sd6, 16'sd8, 16'sd0, 16'sd5, -16'sd7, 16'sd4};

  // ---------------- scoreboard ----------------
  logic [2*WIDTH-1:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [2*WIDTH-1:0] got, input logic [2*WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input logic signed [WIDTH-1:0] av [0:N-1], input logic signed [WIDTH-1:0] bv [0:N-1]);
    for (int i = 0; i < N; i++) begin
      vec_a[i] = av[i];
      vec_b[i] = bv[i];
    end
  endtask

  task automatic load_fill(input logic signed [WIDTH-1:0] av, input logic signed [WIDTH-1:0] bv);
    for (int i = 0; i < N; i++) begin
      vec_a[i] = av;
      vec_b[i] = bv;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    load_fill(16'sd0, 16'sd0);
    #2 rst = 1'b1;
    #1 check("reset_value", result, 32'd0);
    tick();
    tick();
    check("reset_held", result, 32'd0);
    rst = 1'b0;

    // Basic dot product, held steady: 0 before edge L, 116 from edge L on.
    load_vec(basic_a, basic_b);
    for (int e = 1; e <= L + 2; e++) begin
      tick();
      if (e == L - 1) check("basic_early", result, 32'd0);
      if (e >= L)     check("basic", result, 32'd116);
    end

    // Negative operands.
    load_vec(neg_a, neg_b);
    repeat (L) tick();
    check("negative", result, -32'sd52);

    // Overflow wrap: 8 * 2^30 = 2^33 wraps to 0.
    load_fill(-16'sd32768, -16'sd32768);
    repeat (L) tick();
    check("wrap_zero", result, 32'd0);

    // Overflow wrap: 8 * (32767 * -32768) wraps to +262144.
    load_fill(16'sd32767, -16'sd32768);
    repeat (L) tick();
    check("wrap_pos", result, 32'd262144);
    tick();

    // Streaming: basic, all-ones, then zeros on consecutive edges.
    for (int e = 1; e <= L + 2; e++) begin
      if (e == 1) begin
        load_vec(basic_a, basic_b);
        exp_q.push_back(32'd116);
      end else if (e == 2) begin
        load_fill(16'sd1, 16'sd1);
        exp_q.push_back(32'd8);
      end else begin
        load_fill(16'sd0, 16'sd0);
        exp_q.push_back(32'd0);
      end
      tick();
      if (e == L - 1) check("stream_before", result, 32'd262144);
      if (e >= L)     check("stream", result, exp_q.pop_front());
    end

    // Reset mid-stream.
    load_vec(basic_a, basic_b);
    repeat (L + 1) tick();
    check("pre_reset", result, 32'd116);
    #2 rst = 1'b1;
    #1 check("reset_async", result, 32'd0);
    tick();
    check("reset_during", result, 32'd0);
    #2 rst = 1'b0;
    for (int e = 1; e <= L + 1; e++) begin
      tick();
      if (e < L) check("post_reset_zero", result, 32'd0);
      else       check("post_reset_data", result, 32'd116);
    end

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
